agc_timer_ctrl: RTL and testbench
=================================

// Module: agc_timer_ctrl
// PURPOSE
//  Run/halt/single-step sequencer for the AGC timer (a2_timer); drives its STOP input.
//  - Holds the timer stopped through power-on.
//  - Accepts run, halt and N-step requests from the monitor/test harness.
//  - Never stops the timer mid-MCT: a halt is applied only at an MCT_END boundary.
//  - Keeps a free-running count of completed MCTs.
// PARAMETERS
//  PWRON_CYCLES  64  SIM_CLK cycles STOP is held after reset (0 = leave INIT on the first cycle)
//  AUTOSTART     0   1: INIT->RUN; 0: INIT->HALT
//  STEP_W        8   width of STEP_CNT / step remainder
//  CNT_W         16  width of MCT_COUNT
// PORTS
//  SIM_CLK   in   1       sole clock; all logic on posedge
//  SIM_RST   in   1       synchronous, active-high reset
//  MCT_END   in   1       1-cycle pulse from timer logic at the end of each MCT
//  RUN_REQ   in   1       1-cycle pulse: free-run
//  HALT_REQ  in   1       1-cycle pulse: halt at the next MCT boundary
//  STEP_REQ  in   1       1-cycle pulse: run STEP_CNT MCTs, then halt
//  STEP_CNT  in   STEP_W  step count, sampled only on an accepted STEP_REQ
//  STOP      out  1       to a2_timer STOP; registered
//  HALTED    out  1       1 only in state HALT
//  MCT_COUNT out  CNT_W   completed-MCT counter
//  SPUR_ERR  out  1       sticky: MCT_END seen while STOP=1
// BEHAVIOUR
//  Reset values: state=INIT, STOP=1, HALTED=0, MCT_COUNT=0, SPUR_ERR=0, step_rem=0,
//   init counter=0. A reset mid-operation aborts any step or drain immediately.
//  States: INIT, RUN, DRAIN, STEP, HALT. STOP=1 in INIT and HALT; STOP=0 in RUN, DRAIN, STEP.
//  STOP and HALTED are registered and change the cycle after the state transition.
//  INIT: counts PWRON_CYCLES SIM_CLK cycles, then goes to RUN (AUTOSTART=1) or HALT.
//   All requests are ignored in INIT.
//  Request priority when simultaneous: HALT_REQ > RUN_REQ > STEP_REQ.
//  RUN:
//   - HALT_REQ without MCT_END -> DRAIN.
//   - HALT_REQ with MCT_END    -> HALT directly.
//   - RUN_REQ and STEP_REQ are ignored.
//  DRAIN: MCT_END -> HALT. RUN_REQ -> RUN (cancels the halt). STEP_REQ is ignored.
//  HALT:
//   - RUN_REQ -> RUN.
//   - STEP_REQ with STEP_CNT != 0 -> step_rem=STEP_CNT, go to STEP.
//   - STEP_REQ with STEP_CNT == 0 is ignored (stays in HALT).
//   - HALT_REQ is a no-op.
//  STEP: each MCT_END decrements step_rem; MCT_END with step_rem==1 -> HALT.
//   HALT_REQ -> DRAIN; RUN_REQ -> RUN; STEP_REQ is ignored.
//  MCT_COUNT: +1 on each MCT_END while in RUN, DRAIN or STEP. Wraps 2^CNT_W-1 -> 0.
//  SPUR_ERR: set on MCT_END in INIT or HALT. Only SIM_RST clears it. MCT_COUNT is unchanged.
//  Latency: request -> STOP change = 2 SIM_CLK edges (state update, then STOP register).
// CONFIGURATION
//  TIMER_CTRL_BKPT_EN defined:
//   - adds ports BKPT_ARM in 1, BKPT_VAL in CNT_W, BKPT_HIT out 1 (reset 0).
//   - In RUN, DRAIN or STEP, an MCT_END whose incremented MCT_COUNT equals BKPT_VAL
//     with BKPT_ARM=1 -> HALT. BKPT_HIT pulses for 1 cycle.
//   - A breakpoint overrides any pending step remainder; step_rem is cleared.
//  TIMER_CTRL_BKPT_EN undefined: those ports and that logic are absent; behaviour is otherwise identical.
// TESTING
//  1 Power-on: PWRON_CYCLES=64, AUTOSTART=0, SIM_RST high 3 cycles then low
//    -> STOP=1 throughout; HALTED=1 from cycle 66 after reset release; MCT_COUNT=0.
//  2 Run/halt: RUN_REQ, 5 MCT_END pulses, then HALT_REQ mid-MCT
//    -> DRAIN; STOP stays 0 until the next MCT_END, then HALT; MCT_COUNT=6.
//  3 Step: in HALT, STEP_REQ with STEP_CNT=3
//    -> STOP low for exactly 3 MCT_ENDs, then HALT; MCT_COUNT+=3.
//    STEP_CNT=0 -> no change.
//  4 Simultaneous: in HALT, RUN_REQ and STEP_REQ same cycle -> RUN.
//    In RUN, HALT_REQ and MCT_END same cycle -> HALT with no DRAIN cycle.
//  5 Wrap/spurious: preload via 65535 MCTs (CNT_W=16), one more -> MCT_COUNT=0.
//    MCT_END while HALTED -> SPUR_ERR=1, sticky until SIM_RST.
//  6 BKPT (macro on): BKPT_ARM=1, BKPT_VAL=10, RUN from 0
//    -> HALT after the 10th MCT_END; BKPT_HIT is a 1-cycle pulse. SIM_RST mid-DRAIN -> INIT.

Source files
------------

// File: rtl/agc_timer_ctrl.sv
// agc_timer_ctrl: run/halt/single-step sequencer driving the a2_timer STOP input.
// Holds the timer stopped through power-on, only halts on an MCT boundary and
// keeps a free-running count of completed MCTs.
// Optional breakpoint support is built when TIMER_CTRL_BKPT_EN is defined.
module agc_timer_ctrl #(
   parameter int PWRON_CYCLES = 64,
   parameter bit AUTOSTART    = 1'b0,
   parameter int STEP_W       = 8,
   parameter int CNT_W        = 16
) (
   input  logic              SIM_CLK,
   input  logic              SIM_RST,
   input  logic              MCT_END,
   input  logic              RUN_REQ,
   input  logic              HALT_REQ,
   input  logic              STEP_REQ,
   input  logic [STEP_W-1:0] STEP_CNT,
`ifdef TIMER_CTRL_BKPT_EN
   input  logic              BKPT_ARM,
   input  logic [CNT_W-1:0]  BKPT_VAL,
   output logic              BKPT_HIT,
`endif
   output logic              STOP,
   output logic              HALTED,
   output logic [CNT_W-1:0]  MCT_COUNT,
   output logic              SPUR_ERR
);

   localparam int INIT_W = (PWRON_CYCLES < 1) ? 1 : $clog2(PWRON_CYCLES + 1);

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      RUN   = 3'd1,
      DRAIN = 3'd2,
      STEP  = 3'd3,
      HALT  = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [STEP_W-1:0] step_rem;
   logic [STEP_W-1:0] step_rem_nxt;
   logic [INIT_W-1:0] init_cnt;
   logic              init_done;
   logic              mct_active;
   logic [CNT_W-1:0]  count_inc;
   logic              bkpt_fire;

   assign init_done  = (init_cnt == INIT_W'(PWRON_CYCLES));
   assign mct_active = (state == RUN) || (state == DRAIN) || (state == STEP);
   assign count_inc  = MCT_COUNT + CNT_W'(1);

   // State and step remainder register; reset aborts any step or drain at once.
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         state    <= INIT;
         step_rem <= '0;
      end else begin
         state    <= state_nxt;
         step_rem <= step_rem_nxt;
      end
   end

   // Next-state logic; request priority is HALT_REQ > RUN_REQ > STEP_REQ.
   always_comb begin
      state_nxt    = state;
      step_rem_nxt = step_rem;
      bkpt_fire    = 1'b0;
      case (state)
         INIT: begin
            if (init_done) state_nxt = AUTOSTART ? RUN : HALT;
         end
         RUN: begin
            if (HALT_REQ) state_nxt = MCT_END ? HALT : DRAIN;
         end
         DRAIN: begin
            if (HALT_REQ) begin
               if (MCT_END) state_nxt = HALT;
            end else if (RUN_REQ) begin
               state_nxt = RUN;
            end else if (MCT_END) begin
               state_nxt = HALT;
            end
         end
         STEP: begin
            if (HALT_REQ) begin
               state_nxt = MCT_END ? HALT : DRAIN;
            end else if (RUN_REQ) begin
               state_nxt = RUN;
            end else if (MCT_END) begin
               step_rem_nxt = step_rem - STEP_W'(1);
               if (step_rem == STEP_W'(1)) state_nxt = HALT;
            end
         end
         HALT: begin
            // A halt request here is a no-op but still outranks run/step.
            if (!HALT_REQ) begin
               if (RUN_REQ) begin
                  state_nxt = RUN;
               end else if (STEP_REQ && (STEP_CNT != '0)) begin
                  step_rem_nxt = STEP_CNT;
                  state_nxt    = STEP;
               end
            end
         end
         default: state_nxt = INIT;
      endcase
`ifdef TIMER_CTRL_BKPT_EN
      // Breakpoint wins over everything, including a pending step remainder.
      if (mct_active && MCT_END && BKPT_ARM && (count_inc == BKPT_VAL)) begin
         bkpt_fire    = 1'b1;
         state_nxt    = HALT;
         step_rem_nxt = '0;
      end
`endif
   end

   // Power-on counter: counts SIM_CLK cycles spent in INIT.
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         init_cnt <= '0;
      end else if ((state == INIT) && !init_done) begin
         init_cnt <= init_cnt + INIT_W'(1);
      end
   end

   // Completed-MCT counter (wraps) and sticky spurious-MCT flag.
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         MCT_COUNT <= '0;
         SPUR_ERR  <= 1'b0;
      end else begin
         if (mct_active && MCT_END) MCT_COUNT <= count_inc;
         if (MCT_END && ((state == INIT) || (state == HALT))) SPUR_ERR <= 1'b1;
      end
   end

   // Registered outputs follow the state one cycle later.
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) begin
         STOP   <= 1'b1;
         HALTED <= 1'b0;
      end else begin
         STOP   <= (state == INIT) || (state == HALT);
         HALTED <= (state == HALT);
      end
   end

`ifdef TIMER_CTRL_BKPT_EN
   // One-cycle breakpoint hit pulse.
   always_ff @(posedge SIM_CLK) begin
      if (SIM_RST) BKPT_HIT <= 1'b0;
      else         BKPT_HIT <= bkpt_fire;
   end
`else
   logic unused_bkpt;
   assign unused_bkpt = bkpt_fire;
`endif

endmodule

// File: tb/tb_agc_timer_ctrl.sv
// Directed bench for agc_timer_ctrl (default parameters: PWRON_CYCLES=64,
// AUTOSTART=0, STEP_W=8, CNT_W=16). Breakpoint steps are built only when
// TIMER_CTRL_BKPT_EN is defined.
module tb_agc_timer_ctrl;

   logic        SIM_CLK = 1'b0;
   logic        SIM_RST;
   logic        MCT_END;
   logic        RUN_REQ;
   logic        HALT_REQ;
   logic        STEP_REQ;
   logic [7:0]  STEP_CNT;
   logic        STOP;
   logic        HALTED;
   logic [15:0] MCT_COUNT;
   logic        SPUR_ERR;
`ifdef TIMER_CTRL_BKPT_EN
   logic        BKPT_ARM;
   logic [15:0] BKPT_VAL;
   logic        BKPT_HIT;
`endif

   int checks = 0;
   int errors = 0;

   agc_timer_ctrl #(
      .PWRON_CYCLES(64),
      .AUTOSTART   (1'b0),
      .STEP_W      (8),
      .CNT_W       (16)
   ) dut (
      .SIM_CLK  (SIM_CLK),
      .SIM_RST  (SIM_RST),
      .MCT_END  (MCT_END),
      .RUN_REQ  (RUN_REQ),
      .HALT_REQ (HALT_REQ),
      .STEP_REQ (STEP_REQ),
      .STEP_CNT (STEP_CNT),
`ifdef TIMER_CTRL_BKPT_EN
      .BKPT_ARM (BKPT_ARM),
      .BKPT_VAL (BKPT_VAL),
      .BKPT_HIT (BKPT_HIT),
`endif
      .STOP     (STOP),
      .HALTED   (HALTED),
      .MCT_COUNT(MCT_COUNT),
      .SPUR_ERR (SPUR_ERR)
   );

   always #5 SIM_CLK = ~SIM_CLK;

   // Advance one clock edge and settle 1 time unit after it.
   task automatic tick();
      @(posedge SIM_CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One MCT: MCT_END high for one edge, then low for one edge.
   task automatic mct_pulse();
      MCT_END = 1'b1;
      tick();
      MCT_END = 1'b0;
      tick();
   endtask

   // Reset for three cycles, then walk through the 64-cycle power-on window.
   task automatic power_on();
      int stop_low;
      SIM_RST = 1'b1;
      repeat (3) tick();
      SIM_RST = 1'b0;
      stop_low = 0;
      for (int k = 1; k <= 65; k++) begin
         tick();
         if (STOP !== 1'b1) stop_low++;
      end
      check("pwron_stop_held", stop_low, 0);
      check("pwron_halted_c65", HALTED, 1'b0);
      tick();
      check("pwron_halted_c66", HALTED, 1'b1);
      check("pwron_stop_c66", STOP, 1'b1);
      check("pwron_count", MCT_COUNT, 16'd0);
   endtask

   initial begin
      SIM_RST  = 1'b1;
      MCT_END  = 1'b0;
      RUN_REQ  = 1'b0;
      HALT_REQ = 1'b0;
      STEP_REQ = 1'b0;
      STEP_CNT = 8'd0;
`ifdef TIMER_CTRL_BKPT_EN
      BKPT_ARM = 1'b0;
      BKPT_VAL = 16'd0;
`endif

      // Reset state.
      repeat (3) tick();
      check("rst_stop", STOP, 1'b1);
      check("rst_halted", HALTED, 1'b0);
      check("rst_count", MCT_COUNT, 16'd0);
      check("rst_spur", SPUR_ERR, 1'b0);

      // Power-on.
      power_on();

      // Run, five MCTs, halt mid-MCT -> drain until the next MCT_END.
      RUN_REQ = 1'b1;
      tick();
      RUN_REQ = 1'b0;
      check("run_stop_lat1", STOP, 1'b1);
      tick();
      check("run_stop_lat2", STOP, 1'b0);
      check("run_halted", HALTED, 1'b0);
      repeat (5) mct_pulse();
      check("run_count5", MCT_COUNT, 16'd5);
      HALT_REQ = 1'b1;
      tick();
      HALT_REQ = 1'b0;
      tick();
      tick();
      check("drain_stop", STOP, 1'b0);
      check("drain_halted", HALTED, 1'b0);
      MCT_END = 1'b1;
      tick();
      MCT_END = 1'b0;
      check("drain_end_stop_lag", STOP, 1'b0);
      tick();
      check("drain_done_stop", STOP, 1'b1);
      check("drain_done_halted", HALTED, 1'b1);
      check("drain_count6", MCT_COUNT, 16'd6);

      // Step 3 MCTs.
      STEP_CNT = 8'd3;
      STEP_REQ = 1'b1;
      tick();
      STEP_REQ = 1'b0;
      tick();
      check("step_stop_low", STOP, 1'b0);
      repeat (2) mct_pulse();
      check("step_after2_stop", STOP, 1'b0);
      check("step_after2_halted", HALTED, 1'b0);
      mct_pulse();
      check("step_done_stop", STOP, 1'b1);
      check("step_done_halted", HALTED, 1'b1);
      check("step_count9", MCT_COUNT, 16'd9);

      // Step with STEP_CNT=0 is ignored.
      STEP_CNT = 8'd0;
      STEP_REQ = 1'b1;
      tick();
      STEP_REQ = 1'b0;
      tick();
      tick();
      check("step0_stop", STOP, 1'b1);
      check("step0_halted", HALTED, 1'b1);
      check("step0_count", MCT_COUNT, 16'd9);

      // RUN_REQ + STEP_REQ together -> RUN (no halt after 2 MCTs).
      STEP_CNT = 8'd2;
      RUN_REQ  = 1'b1;
      STEP_REQ = 1'b1;
      tick();
      RUN_REQ  = 1'b0;
      STEP_REQ = 1'b0;
      tick();
      check("simul_run_stop", STOP, 1'b0);
      repeat (3) mct_pulse();
      check("simul_still_run", STOP, 1'b0);
      check("simul_count12", MCT_COUNT, 16'd12);

      // HALT_REQ + MCT_END together in RUN -> HALT without a DRAIN cycle.
      HALT_REQ = 1'b1;
      MCT_END  = 1'b1;
      tick();
      HALT_REQ = 1'b0;
      MCT_END  = 1'b0;
      check("direct_halt_lag", HALTED, 1'b0);
      tick();
      check("direct_halt_halted", HALTED, 1'b1);
      check("direct_halt_stop", STOP, 1'b1);
      check("direct_halt_count13", MCT_COUNT, 16'd13);

      // Spurious MCT_END while halted.
      mct_pulse();
      check("spur_set", SPUR_ERR, 1'b1);
      check("spur_count_hold", MCT_COUNT, 16'd13);
      tick();
      check("spur_sticky", SPUR_ERR, 1'b1);

      // Wrap: run to 65535, then one more MCT -> 0.
      RUN_REQ = 1'b1;
      tick();
      RUN_REQ = 1'b0;
      MCT_END = 1'b1;
      repeat (65522) tick();
      check("wrap_max", MCT_COUNT, 16'hFFFF);
      tick();
      MCT_END = 1'b0;
      check("wrap_zero", MCT_COUNT, 16'd0);
      check("spur_still_set", SPUR_ERR, 1'b1);

      // Reset clears the sticky flag and returns to INIT.
      SIM_RST = 1'b1;
      tick();
      SIM_RST = 1'b0;
      check("rst2_spur", SPUR_ERR, 1'b0);
      check("rst2_stop", STOP, 1'b1);
      check("rst2_halted", HALTED, 1'b0);
      check("rst2_count", MCT_COUNT, 16'd0);

`ifdef TIMER_CTRL_BKPT_EN
      // Breakpoint at MCT 10.
      power_on();
      BKPT_ARM = 1'b1;
      BKPT_VAL = 16'd10;
      RUN_REQ  = 1'b1;
      tick();
      RUN_REQ = 1'b0;
      tick();
      repeat (9) mct_pulse();
      check("bkpt_not_yet", BKPT_HIT, 1'b0);
      MCT_END = 1'b1;
      tick();
      MCT_END = 1'b0;
      check("bkpt_hit", BKPT_HIT, 1'b1);
      check("bkpt_count10", MCT_COUNT, 16'd10);
      tick();
      check("bkpt_hit_pulse", BKPT_HIT, 1'b0);
      check("bkpt_halted", HALTED, 1'b1);

      // Reset while draining -> INIT.
      BKPT_ARM = 1'b0;
      RUN_REQ  = 1'b1;
      tick();
      RUN_REQ  = 1'b0;
      HALT_REQ = 1'b1;
      tick();
      HALT_REQ = 1'b0;
      SIM_RST  = 1'b1;
      tick();
      SIM_RST = 1'b0;
      tick();
      check("bkpt_rst_stop", STOP, 1'b1);
      check("bkpt_rst_halted", HALTED, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
